// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates and colour from a raw VGA
// stream (hsync, vsync, 4-bit RGB). The decoder hunts for a vsync leading
// edge, verifies one full frame of sync timing, then stays locked while
// every sync edge lands where the timing parameters say it should.
// While locked it produces a 16-bit checksum and a count of complete frames.
//
// Stream qualifier: pix_valid is a single-cycle qualifier, with no
// backpressure. When pix_valid is 1, pix_x/pix_y/pix_r/pix_g/pix_b describe
// one visible pixel of a locked stream. When pix_valid is 0, those buses
// still carry the sample-stage values and must not be treated as image data.
module vga_sync_decoder #(
  parameter int H_DISPLAY        = 640,
  parameter int H_FRONT          = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BACK           = 48,
  parameter int V_DISPLAY        = 480,
  parameter int V_BOTTOM         = 10,
  parameter int V_SYNC           = 2,
  parameter int V_TOP            = 33,
  parameter int SYNC_ACTIVE_HIGH = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [3:0]  vga_r,
  input  logic [3:0]  vga_g,
  input  logic [3:0]  vga_b,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [3:0]  pix_r,
  output logic [3:0]  pix_g,
  output logic [3:0]  pix_b,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic [15:0] frame_count,
  output logic        sync_err,
  output logic [7:0]  err_count,
  output logic [1:0]  dbg_state
);

  localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;

  localparam logic [9:0] H_LAST_C  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST_C  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SS_C    = 10'(H_SYNC_START);
  localparam logic [9:0] V_SS_C    = 10'(V_SYNC_START);
  localparam logic [9:0] H_DISP_C  = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP_C  = 10'(V_DISPLAY);
  localparam logic       SYNC_INV  = (SYNC_ACTIVE_HIGH == 0);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t state, state_next;

  // Sample stage S: one register stage on every input, syncs normalised
  logic       hs_norm, vs_norm;
  logic       s_hs, s_vs, s_hs_edge, s_vs_edge;
  logic [3:0] s_r, s_g, s_b;

  // Counters describing the S-sample, plus per-frame bookkeeping
  logic [9:0]  x, y, x_next, y_next, cur_x, cur_y;
  logic        bad, bad_next;
  logic [15:0] acc, acc_next;
  logic        reload;
  logic        done_next, err_next;
  logic [15:0] sum_next, fcount_next;
  logic [7:0]  ecount_next;

  logic hs_exp, vs_exp, mismatch, visible;

  assign hs_norm   = vga_hs ^ SYNC_INV;
  assign vs_norm   = vga_vs ^ SYNC_INV;
  assign dbg_state = state;

  // Where the sync edges belong for the S-sample the counters describe.
  // A simultaneous hsync/vsync error collapses into one mismatch.
  assign hs_exp   = (x == H_SS_C);
  assign vs_exp   = (x == 10'd0) && (y == V_SS_C);
  assign mismatch = (s_hs_edge != hs_exp) || (s_vs_edge != vs_exp);
  assign visible  = (cur_x < H_DISP_C) && (cur_y < V_DISP_C);

  // Register inputs; edge flags compare the new sample with the one held in S
  always_ff @(posedge clk) begin
    if (reset) begin
      s_hs      <= 1'b0;
      s_vs      <= 1'b0;
      s_hs_edge <= 1'b0;
      s_vs_edge <= 1'b0;
      s_r       <= 4'd0;
      s_g       <= 4'd0;
      s_b       <= 4'd0;
    end else begin
      s_hs      <= hs_norm;
      s_vs      <= vs_norm;
      s_hs_edge <= hs_norm & ~s_hs;
      s_vs_edge <= vs_norm & ~s_vs;
      s_r       <= vga_r;
      s_g       <= vga_g;
      s_b       <= vga_b;
    end
  end

  // Next-state, counter, checksum and event logic for the lock FSM
  always_comb begin
    state_next  = state;
    bad_next    = bad;
    acc_next    = acc;
    done_next   = 1'b0;
    err_next    = 1'b0;
    sum_next    = frame_sum;
    fcount_next = frame_count;
    ecount_next = err_count;
    reload      = 1'b0;
    cur_x       = x;
    cur_y       = y;
    x_next      = x;
    y_next      = y;

    case (state)
      ST_HUNT: begin
        // hsync is ignored until a frame reference exists
        if (s_vs_edge) begin
          reload     = 1'b1;
          bad_next   = 1'b0;
          state_next = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (s_vs_edge) begin
          if (mismatch || bad) begin
            // restart verification from this vsync edge
            reload   = 1'b1;
            bad_next = 1'b0;
          end else begin
            state_next = ST_LOCKED;
            acc_next   = 16'd0;
          end
        end else if (mismatch) begin
          bad_next = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (mismatch) begin
          state_next = ST_HUNT;
          err_next   = 1'b1;
          acc_next   = 16'd0;
          if (err_count != 8'hFF) ecount_next = err_count + 8'd1;
        end else if (s_vs_edge) begin
          done_next   = 1'b1;
          sum_next    = acc;
          fcount_next = frame_count + 16'd1;
          acc_next    = 16'd0;
        end else if (visible) begin
          acc_next = acc + {4'b0000, s_r, s_g, s_b};
        end
      end
      default: begin
        state_next = ST_HUNT;
      end
    endcase

    // A reload re-anchors the current S-sample at the vsync start position
    if (reload) begin
      cur_x = 10'd0;
      cur_y = V_SS_C;
    end

    if (cur_x == H_LAST_C) begin
      x_next = 10'd0;
      y_next = (cur_y == V_LAST_C) ? 10'd0 : cur_y + 10'd1;
    end else begin
      x_next = cur_x + 10'd1;
      y_next = cur_y;
    end
  end

  // FSM state, counters, accumulator and frame/error statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_HUNT;
      x           <= 10'd0;
      y           <= 10'd0;
      bad         <= 1'b0;
      acc         <= 16'd0;
      locked      <= 1'b0;
      frame_done  <= 1'b0;
      frame_sum   <= 16'd0;
      frame_count <= 16'd0;
      sync_err    <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      state       <= state_next;
      x           <= x_next;
      y           <= y_next;
      bad         <= bad_next;
      acc         <= acc_next;
      locked      <= (state_next == ST_LOCKED);
      frame_done  <= done_next;
      frame_sum   <= sum_next;
      frame_count <= fcount_next;
      sync_err    <= err_next;
      err_count   <= ecount_next;
    end
  end

  // Pixel output stage: S-stage values always, qualified by pix_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid <= 1'b0;
      pix_x     <= 10'd0;
      pix_y     <= 10'd0;
      pix_r     <= 4'd0;
      pix_g     <= 4'd0;
      pix_b     <= 4'd0;
    end else begin
      pix_valid <= (state == ST_LOCKED) && visible;
      pix_x     <= cur_x;
      pix_y     <= cur_y;
      pix_r     <= s_r;
      pix_g     <= s_g;
      pix_b     <= s_b;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a small 16x12 raster so many frames fit in
// a short run. A generator task drives one pixel per cycle on the falling
// edge; a per-cycle monitor records lock, error and frame events with their
// cycle index, and directed checks compare them with hand-computed values.
//
// Raster: H 8+2+3+3 = 16 (hsync start x=10), V 6+2+2+2 = 12 (vsync start
// y=8), 192 cycles per frame. Pixel k (k = cycles since reset release) is
// at x=k%16, line k/16. Pixel k reaches S at posedge k+1, so events derived
// from it are registered at posedge k+2 and observed at tick k+2.
module tb_vga_sync_decoder;

  localparam int HD  = 8;
  localparam int HF  = 2;
  localparam int HSY = 3;
  localparam int HB  = 3;
  localparam int VD  = 6;
  localparam int VB  = 2;
  localparam int VSY = 2;
  localparam int VT  = 2;
  localparam int HTOT = HD + HF + HSY + HB;
  localparam int VTOT = VD + VB + VSY + VT;
  localparam int HSS  = HD + HF;
  localparam int VSS  = VD + VB;

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Stimulus and DUT wiring (dut: active-high sync, dut_n: active-low sync)
  logic        vga_hs, vga_vs, vga_hs_n, vga_vs_n;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        locked, pix_valid, frame_done, sync_err;
  logic [9:0]  pix_x, pix_y;
  logic [3:0]  pix_r, pix_g, pix_b;
  logic [15:0] frame_sum, frame_count;
  logic [7:0]  err_count;
  logic [1:0]  dbg_state;
  logic        locked_n, pix_valid_n, frame_done_n, sync_err_n;
  logic [9:0]  pix_x_n, pix_y_n;
  logic [3:0]  pix_r_n, pix_g_n, pix_b_n;
  logic [15:0] frame_sum_n, frame_count_n;
  logic [7:0]  err_count_n;
  logic [1:0]  dbg_state_n;

  vga_sync_decoder #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VSY), .V_TOP(VT),
    .SYNC_ACTIVE_HIGH(1)
  ) dut (
    .clk(clk), .reset(reset), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .locked(locked), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .frame_done(frame_done), .frame_sum(frame_sum), .frame_count(frame_count),
    .sync_err(sync_err), .err_count(err_count), .dbg_state(dbg_state)
  );

  vga_sync_decoder #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VSY), .V_TOP(VT),
    .SYNC_ACTIVE_HIGH(0)
  ) dut_n (
    .clk(clk), .reset(reset), .vga_hs(vga_hs_n), .vga_vs(vga_vs_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .locked(locked_n), .pix_valid(pix_valid_n), .pix_x(pix_x_n), .pix_y(pix_y_n),
    .pix_r(pix_r_n), .pix_g(pix_g_n), .pix_b(pix_b_n),
    .frame_done(frame_done_n), .frame_sum(frame_sum_n), .frame_count(frame_count_n),
    .sync_err(sync_err_n), .err_count(err_count_n), .dbg_state(dbg_state_n)
  );

  // Scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;
  int mode     = 0;    // 0: all visible pixels 0xFFF, 1: red 0xA at (5,3)
  int drop_line = -1;  // absolute line whose hsync pulse is suppressed
  logic prev_locked = 1'b0;
  logic prev_locked_n = 1'b0;
  int lock_rise_t = -1, lock_fall_t = -1, lock_rise_n_t = -1;
  int err_t = -1, n_err = 0, n_err_n = 0;
  logic [31:0] done_t_q[$];
  logic [31:0] sum_q[$];
  logic [31:0] cnt_q[$];
  logic [31:0] sum_n_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic check_zero(input string p);
    check_eq({p, "_locked"},      32'(locked), 0);
    check_eq({p, "_pix_valid"},   32'(pix_valid), 0);
    check_eq({p, "_pix_x"},       32'(pix_x), 0);
    check_eq({p, "_pix_y"},       32'(pix_y), 0);
    check_eq({p, "_pix_rgb"},     32'({pix_r, pix_g, pix_b}), 0);
    check_eq({p, "_frame_done"},  32'(frame_done), 0);
    check_eq({p, "_frame_sum"},   32'(frame_sum), 0);
    check_eq({p, "_frame_count"}, 32'(frame_count), 0);
    check_eq({p, "_sync_err"},    32'(sync_err), 0);
    check_eq({p, "_err_count"},   32'(err_count), 0);
    check_eq({p, "_state"},       32'(dbg_state), 0);
  endtask

  // Generator model: drives pixel k onto the pins (both polarities)
  task automatic drive_pixel(input int k);
    int gx, gy, line;
    logic hs, vs;
    logic [3:0] r, g, b;
    gx   = k % HTOT;
    line = k / HTOT;
    gy   = line % VTOT;
    hs   = (gx >= HSS) && (gx < HSS + HSY) && (line != drop_line);
    vs   = (gy >= VSS) && (gy < VSS + VSY);
    r = 4'd0; g = 4'd0; b = 4'd0;
    if (gx < HD && gy < VD) begin
      if (mode == 0) begin
        r = 4'hF; g = 4'hF; b = 4'hF;
      end else if (gx == 5 && gy == 3) begin
        r = 4'hA;
      end
    end
    vga_hs = hs;  vga_vs = vs;
    vga_hs_n = ~hs; vga_vs_n = ~vs;
    vga_r = r; vga_g = g; vga_b = b;
  endtask

  task automatic drive_idle();
    vga_hs = 1'b0; vga_vs = 1'b0;
    vga_hs_n = 1'b1; vga_vs_n = 1'b1;
    vga_r = 4'd0; vga_g = 4'd0; vga_b = 4'd0;
  endtask

  // One cycle: observe on the falling edge, then drive the next pixel
  task automatic tick();
    @(negedge clk);
    if (locked && !prev_locked) lock_rise_t = t;
    if (!locked && prev_locked) lock_fall_t = t;
    if (locked_n && !prev_locked_n) lock_rise_n_t = t;
    if (sync_err) begin
      n_err++;
      err_t = t;
    end
    if (sync_err_n) n_err_n++;
    if (frame_done) begin
      done_t_q.push_back(32'(t));
      sum_q.push_back(32'(frame_sum));
      cnt_q.push_back(32'(frame_count));
    end
    if (frame_done_n) sum_n_q.push_back(32'(frame_sum_n));
    prev_locked   = locked;
    prev_locked_n = locked_n;
    drive_pixel(t);
    t++;
  endtask

  task automatic run_to(input int last);
    while (t <= last) tick();
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    check_zero("rst");
    reset = 1'b0;
    t = 0;

    // Lock acquisition: vsync edges at pixels 128 and 320
    mode = 0;
    run_to(330);
    check_eq("lock_rise_t", 32'(lock_rise_t), 322);
    check_eq("lock_rise_t_low_pol", 32'(lock_rise_n_t), 322);
    check_eq("no_sync_err", 32'(n_err), 0);
    check_eq("no_sync_err_low_pol", 32'(n_err_n), 0);
    check_eq("err_count_clean", 32'(err_count), 0);

    // Constant 0xFFF frames: 48 * 0xFFF mod 2^16 = 0xFFD0
    run_to(719);
    check_eq("done_num", 32'(done_t_q.size()), 2);
    check_eq("done_t0", done_t_q[0], 514);
    check_eq("done_t1", done_t_q[1], 706);
    check_eq("sum0", sum_q[0], 32'hFFD0);
    check_eq("sum1", sum_q[1], 32'hFFD0);
    check_eq("count0", cnt_q[0], 1);
    check_eq("count1", cnt_q[1], 2);
    check_eq("sum0_low_pol", sum_n_q[0], 32'hFFD0);

    // Single red pixel at (5,3): pixel 768+53=821, visible on pix_* at 823
    mode = 1;
    run_to(823);
    check_eq("px_valid", 32'(pix_valid), 1);
    check_eq("px_x", 32'(pix_x), 5);
    check_eq("px_y", 32'(pix_y), 3);
    check_eq("px_r", 32'(pix_r), 32'hA);
    check_eq("px_gb", 32'({pix_g, pix_b}), 0);
    run_to(826);
    check_eq("px_blank_valid", 32'(pix_valid), 0);
    check_eq("px_blank_x", 32'(pix_x), 8);
    run_to(900);
    check_eq("done_t2", done_t_q[2], 898);
    check_eq("sum2_red", sum_q[2], 32'h0A00);
    check_eq("count2", cnt_q[2], 3);

    // Drop the hsync pulse on line 62 (expected at pixel 1002)
    drop_line = 62;
    run_to(1290);
    check_eq("drop1_err_t", 32'(err_t), 1004);
    check_eq("drop1_err_pulses", 32'(n_err), 1);
    check_eq("drop1_err_count", 32'(err_count), 1);
    check_eq("drop1_lock_fall", 32'(lock_fall_t), 1004);
    check_eq("drop1_relock", 32'(lock_rise_t), 1282);

    // Two more drops to reach err_count 3, each followed by a re-lock
    drop_line = 84;
    run_to(1670);
    check_eq("drop2_err_t", 32'(err_t), 1356);
    check_eq("drop2_relock", 32'(lock_rise_t), 1666);
    drop_line = 108;
    run_to(2200);
    check_eq("drop3_err_t", 32'(err_t), 1740);
    check_eq("drop3_relock", 32'(lock_rise_t), 2050);
    check_eq("err_count3", 32'(err_count), 3);
    check_eq("locked_pre_reset", 32'(locked), 1);
    check_eq("state_pre_reset", 32'(dbg_state), 2);

    // Mid-frame reset while locked
    reset = 1'b1;
    @(negedge clk);
    check_zero("mid");

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
